// File: rtl/odd_sweep_controller_pkg.sv
// Shared types, default widths and helpers for the odd sweep controller.
// Optional Pause input is enabled by defining ODD_SWEEP_PAUSE_EN.
package odd_sweep_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_DWELL_W  = 4;
   localparam int DEF_SWEEPS_W = 4;

   function automatic logic is_odd(input logic [31:0] v);
      return (v & 32'd1) != 32'd0;
   endfunction

endpackage

// File: rtl/odd_sweep_controller_if.sv
// Config/status bundle between the register front end (master) and the sweep controller (slave).
// The pause signal exists only when ODD_SWEEP_PAUSE_EN is defined.
interface odd_sweep_if #(
   parameter int N        = odd_sweep_pkg::DEF_N,
   parameter int DWELL_W  = odd_sweep_pkg::DEF_DWELL_W,
   parameter int SWEEPS_W = odd_sweep_pkg::DEF_SWEEPS_W
);
   logic                start;
   logic                abort;
   logic [N-1:0]        low_lim;
   logic [N-1:0]        high_lim;
   logic [DWELL_W-1:0]  dwell;
   logic [SWEEPS_W-1:0] sweeps;
`ifdef ODD_SWEEP_PAUSE_EN
   logic                pause;
`endif
   logic [N-1:0]        q;
   logic                up;
   logic                busy;
   logic                done;
   logic                cfg_err;
   logic [SWEEPS_W-1:0] sweep_cnt;

   modport master (
      output start, abort, low_lim, high_lim, dwell, sweeps,
`ifdef ODD_SWEEP_PAUSE_EN
      output pause,
`endif
      input  q, up, busy, done, cfg_err, sweep_cnt
   );

   modport slave (
      input  start, abort, low_lim, high_lim, dwell, sweeps,
`ifdef ODD_SWEEP_PAUSE_EN
      input  pause,
`endif
      output q, up, busy, done, cfg_err, sweep_cnt
   );
endinterface

// File: rtl/odd_sweep_controller_counter.sv
// Registered N-bit odd counter: loads a start value or steps by +/-2 (mod 2^N); resets to 1.
module odd_step_counter #(
   parameter int N = odd_sweep_pkg::DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         step,
   input  logic         up,
   output logic [N-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= N'(1);
      end else if (load) begin
         q <= load_val;
      end else if (step) begin
         q <= up ? q + N'(2) : q - N'(2);
      end
   end

endmodule

// File: rtl/odd_sweep_controller.sv
// Triangular odd-value sweep sequencer with per-value dwell and sweep counting.
// Define ODD_SWEEP_PAUSE_EN to add a pause input that freezes the sweep in RUN.
import odd_sweep_pkg::*;

module odd_sweep_controller #(
   parameter int N        = DEF_N,
   parameter int DWELL_W  = DEF_DWELL_W,
   parameter int SWEEPS_W = DEF_SWEEPS_W
) (
   input logic        clk,
   input logic        rst,
   odd_sweep_if.slave bus
);

   state_t              state, state_nxt;
   logic [N-1:0]        lo_r, hi_r, q, q_step;
   logic [DWELL_W-1:0]  dwell_r, timer;
   logic [SWEEPS_W-1:0] sweeps_r, sweep_cnt;
   logic                up_r, cfg_err_r, paused, cfg_ok;
   logic                accept, load, run_act, step, hit_hi, hit_lo, last_sweep;
   logic                busy, done;

`ifdef ODD_SWEEP_PAUSE_EN
   assign paused = bus.pause;
`else
   assign paused = 1'b0;
`endif

   assign cfg_ok     = is_odd(32'(bus.low_lim)) && is_odd(32'(bus.high_lim)) &&
                       (bus.low_lim < bus.high_lim);
   assign q_step     = up_r ? q + N'(2) : q - N'(2);
   assign hit_hi     = up_r && (q_step == hi_r);
   assign hit_lo     = !up_r && (q_step == lo_r);
   assign last_sweep = (sweeps_r != '0) && ((sweep_cnt + SWEEPS_W'(1)) == sweeps_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start && !bus.abort && cfg_ok) state_nxt = LOAD;
         LOAD: state_nxt = bus.abort ? IDLE : RUN;
         RUN: begin
            if (bus.abort)                   state_nxt = IDLE;
            else if (step && hit_lo && last_sweep) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      done    = (state == DONE);
      accept  = (state == IDLE) && bus.start && !bus.abort;
      load    = (state == LOAD) && !bus.abort;
      run_act = (state == RUN) && !bus.abort && !paused;
      step    = run_act && (timer == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_r      <= '0;
         hi_r      <= '0;
         dwell_r   <= '0;
         sweeps_r  <= '0;
         timer     <= '0;
         up_r      <= 1'b1;
         cfg_err_r <= 1'b0;
         sweep_cnt <= '0;
      end else begin
         if (accept) begin
            if (cfg_ok) begin
               lo_r      <= bus.low_lim;
               hi_r      <= bus.high_lim;
               dwell_r   <= bus.dwell;
               sweeps_r  <= bus.sweeps;
               cfg_err_r <= 1'b0;
               sweep_cnt <= '0;
            end else begin
               cfg_err_r <= 1'b1;
            end
         end
         if (load) begin
            up_r  <= 1'b1;
            timer <= dwell_r;
         end
         if (run_act) begin
            if (timer != '0) begin
               timer <= timer - DWELL_W'(1);
            end else begin
               timer <= dwell_r;
               if (hit_hi) begin
                  up_r <= 1'b0;
               end else if (hit_lo) begin
                  // Sweeps=0 lets the count wrap; the final sweep keeps Up low.
                  sweep_cnt <= sweep_cnt + SWEEPS_W'(1);
                  if (!last_sweep) up_r <= 1'b1;
               end
            end
         end
      end
   end

   odd_step_counter #(.N(N)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (lo_r),
      .step     (step),
      .up       (up_r),
      .q        (q)
   );

   assign bus.q         = q;
   assign bus.up        = up_r;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.cfg_err   = cfg_err_r;
   assign bus.sweep_cnt = sweep_cnt;

endmodule
